// File: rtl/control_sequencer_if.sv
// Handshake and control bus between the hardwired control sequencer and the
// memory / instruction register / datapath side.
interface control_sequencer_if;
  logic        run;
  logic [31:0] ir;
  logic        mem_rdy;
  logic [31:0] enable;
  logic [31:0] busSelect;
  logic        MD_Read;
  logic        IncPC;
  logic [3:0]  Control_Signals;
  logic        busy;
  logic        fault;

  // Sequencer side
  modport master (
    input  run, ir, mem_rdy,
    output enable, busSelect, MD_Read, IncPC, Control_Signals, busy, fault
  );

  // Datapath / memory side
  modport slave (
    output run, ir, mem_rdy,
    input  enable, busSelect, MD_Read, IncPC, Control_Signals, busy, fault
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired T0..T5 fetch/execute sequencer for 3-register ALU instructions.
// Optional CTRL_SINGLE_STEP_EN adds a step input: one instruction per step rising edge.
module control_sequencer #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int OP_W         = 5
) (
  input  logic                clk,
  input  logic                clr,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic                step,
`endif
  control_sequencer_if.master bus
);

  localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

  // Datapath bit positions
  localparam int EN_PC  = 20;
  localparam int EN_MDR = 21;
  localparam int EN_IR  = 23;
  localparam int EN_Z   = 24;
  localparam int EN_MAR = 25;
  localparam int EN_Y   = 27;
  localparam int BS_ZLO = 19;
  localparam int BS_PC  = 20;
  localparam int BS_MDR = 21;

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_FAULT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             fault_q;

  logic [OP_W-1:0]  op;
  logic [3:0]       ra, rb, rc;
  logic [3:0]       alu_code;
  logic             op_legal;
  logic             start;

  assign op = bus.ir[31 -: OP_W];
  assign ra = bus.ir[26:23];
  assign rb = bus.ir[22:19];
  assign rc = bus.ir[18:15];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    alu_code = 4'd0;
    op_legal = 1'b1;
    case (op)
      OP_W'(5'b00011): alu_code = 4'd1;
      OP_W'(5'b00100): alu_code = 4'd2;
      OP_W'(5'b00101): alu_code = 4'd3;
      OP_W'(5'b00110): alu_code = 4'd4;
      default:         op_legal = 1'b0;
    endcase
  end

`ifdef CTRL_SINGLE_STEP_EN
  logic step_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) step_q <= 1'b0;
    else      step_q <= step;
  end

  assign start = bus.run & step & ~step_q;
`else
  assign start = bus.run;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_T0;
        S_T0:   state <= S_T1;
        S_T1: begin
          // mem_rdy wins over a timeout landing on the same cycle
          if (bus.mem_rdy) begin
            state    <= S_T2;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= S_FAULT;
            fault_q  <= 1'b1;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_T2:   state <= S_T3;
        S_T3: begin
          if (op_legal) begin
            state <= S_T4;
          end else begin
            state   <= S_FAULT;
            fault_q <= 1'b1;
          end
        end
        S_T4:   state <= S_T5;
        S_T5: begin
`ifdef CTRL_SINGLE_STEP_EN
          state <= S_IDLE;
`else
          state <= bus.run ? S_T0 : S_IDLE;
`endif
        end
        S_FAULT: state <= S_FAULT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore decode: only state plus the IR fields in T3..T5
  logic [31:0] enable_c, bus_sel_c;
  logic        md_read_c, inc_pc_c;
  logic [3:0]  ctrl_c;

  always_comb begin
    enable_c  = '0;
    bus_sel_c = '0;
    md_read_c = 1'b0;
    inc_pc_c  = 1'b0;
    ctrl_c    = 4'd0;
    case (state)
      S_T0: begin
        bus_sel_c[BS_PC]  = 1'b1;
        enable_c[EN_MAR]  = 1'b1;
        enable_c[EN_Z]    = 1'b1;
        inc_pc_c          = 1'b1;
      end
      S_T1: begin
        bus_sel_c[BS_ZLO] = 1'b1;
        enable_c[EN_PC]   = 1'b1;
        enable_c[EN_MDR]  = 1'b1;
        md_read_c         = 1'b1;
      end
      S_T2: begin
        bus_sel_c[BS_MDR] = 1'b1;
        enable_c[EN_IR]   = 1'b1;
      end
      S_T3: begin
        if (op_legal) begin
          bus_sel_c       = 32'h1 << rb;
          enable_c[EN_Y]  = 1'b1;
        end
      end
      S_T4: begin
        bus_sel_c         = 32'h1 << rc;
        ctrl_c            = alu_code;
        enable_c[EN_Z]    = 1'b1;
      end
      S_T5: begin
        bus_sel_c[BS_ZLO] = 1'b1;
        enable_c          = 32'h1 << ra;
      end
      default: ;
    endcase
  end

  assign bus.enable          = enable_c;
  assign bus.busSelect       = bus_sel_c;
  assign bus.MD_Read         = md_read_c;
  assign bus.IncPC           = inc_pc_c;
  assign bus.Control_Signals = ctrl_c;
  assign bus.busy            = (state != S_IDLE) && (state != S_FAULT);
  assign bus.fault           = fault_q | ((state == S_T3) && !op_legal);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: hand-computed outputs per T-state,
// memory wait, timeout fault, illegal opcode, async reset and back-to-back runs.
module tb_control_sequencer;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  control_sequencer_if bus ();

`ifdef CTRL_SINGLE_STEP_EN
  logic step = 1'b0;
`endif

  control_sequencer dut (
    .clk  (clk),
    .clr  (clr),
`ifdef CTRL_SINGLE_STEP_EN
    .step (step),
`endif
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'h0};
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, " enable"},    bus.enable, 32'h0);
    check({tag, " busSelect"}, bus.busSelect, 32'h0);
    check({tag, " MD_Read"},   32'(bus.MD_Read), 32'h0);
    check({tag, " IncPC"},     32'(bus.IncPC), 32'h0);
    check({tag, " ctrl"},      32'(bus.Control_Signals), 32'h0);
    check({tag, " busy"},      32'(bus.busy), 32'h0);
  endtask

  // Called just after entering T0; runs one instruction with mem_rdy delayed by `delay` T1 cycles.
  task automatic do_instr(input string tag, input logic [31:0] ir_v, input int delay,
                          input logic run_next, input logic [31:0] rb_sel,
                          input logic [31:0] rc_sel, input logic [31:0] ra_en,
                          input logic [3:0] code);
    bus.ir = ir_v;
    check({tag, " T0 busSelect"}, bus.busSelect, 32'h0010_0000);
    check({tag, " T0 enable"},    bus.enable,    32'h0300_0000);
    check({tag, " T0 IncPC"},     32'(bus.IncPC), 32'h1);
    check({tag, " T0 busy"},      32'(bus.busy), 32'h1);
    bus.mem_rdy = 1'b0;
    tick();
    for (int k = 0; k <= delay; k++) begin
      bus.mem_rdy = (k == delay);
      check({tag, " T1 busSelect"}, bus.busSelect, 32'h0008_0000);
      check({tag, " T1 enable"},    bus.enable,    32'h0030_0000);
      check({tag, " T1 MD_Read"},   32'(bus.MD_Read), 32'h1);
      tick();
    end
    bus.mem_rdy = 1'b0;
    check({tag, " T2 busSelect"}, bus.busSelect, 32'h0020_0000);
    check({tag, " T2 enable"},    bus.enable,    32'h0080_0000);
    check({tag, " T2 MD_Read"},   32'(bus.MD_Read), 32'h0);
    tick();
    check({tag, " T3 busSelect"}, bus.busSelect, rb_sel);
    check({tag, " T3 enable"},    bus.enable,    32'h0800_0000);
    tick();
    check({tag, " T4 busSelect"}, bus.busSelect, rc_sel);
    check({tag, " T4 enable"},    bus.enable,    32'h0100_0000);
    check({tag, " T4 ctrl"},      32'(bus.Control_Signals), 32'(code));
    tick();
    check({tag, " T5 busSelect"}, bus.busSelect, 32'h0008_0000);
    check({tag, " T5 enable"},    bus.enable,    ra_en);
    check({tag, " T5 ctrl"},      32'(bus.Control_Signals), 32'h0);
    check({tag, " T5 busy"},      32'(bus.busy), 32'h1);
    bus.run = run_next;
    tick();
    if (run_next) check({tag, " next T0 IncPC"}, 32'(bus.IncPC), 32'h1);
    else          check_quiet({tag, " idle"});
  endtask

  task automatic pulse_clr();
    clr = 1'b0;
    #1;
    check("clr fault", 32'(bus.fault), 32'h0);
    check("clr busy",  32'(bus.busy), 32'h0);
    tick();
    clr = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr = 1'b0;
    bus.run = 1'b0;
    bus.mem_rdy = 1'b0;
    bus.ir = 32'h0;
    #3;
    check_quiet("reset");
    check("reset fault", 32'(bus.fault), 32'h0);
    #9 clr = 1'b1;
    tick();
    check_quiet("idle no run");

    // AND R1,R2,R3 with immediate mem_rdy
    bus.run = 1'b1;
    tick();
    do_instr("and", 32'h2891_8000, 0, 1'b0, 32'h4, 32'h8, 32'h2, 4'd3);

    // OR R10,R11,R12 with mem_rdy delayed 3 cycles
    bus.run = 1'b1;
    tick();
    do_instr("or", mk_ir(5'b00110, 4'd10, 4'd11, 4'd12), 3, 1'b0,
             32'h800, 32'h1000, 32'h400, 4'd4);

    // ADD R4,R5,R6 then SUB R7,R8,R9 back to back
    bus.run = 1'b1;
    tick();
    do_instr("add", mk_ir(5'b00011, 4'd4, 4'd5, 4'd6), 0, 1'b1,
             32'h20, 32'h40, 32'h10, 4'd1);
    do_instr("sub", mk_ir(5'b00100, 4'd7, 4'd8, 4'd9), 1, 1'b0,
             32'h100, 32'h200, 32'h80, 4'd2);

    // Async reset mid-T4
    bus.ir = 32'h2891_8000;
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    bus.mem_rdy = 1'b1;
    tick();
    tick();
    bus.mem_rdy = 1'b0;
    tick();
    tick();
    check("midT4 ctrl", 32'(bus.Control_Signals), 32'h3);
    #1 clr = 1'b0;
    #1;
    check_quiet("async reset");
    check("async reset fault", 32'(bus.fault), 32'h0);
    tick();
    clr = 1'b1;
    tick();
    check_quiet("after reset idle");

    // Illegal opcode
    bus.ir = mk_ir(5'b11111, 4'd1, 4'd2, 4'd3);
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    bus.mem_rdy = 1'b1;
    tick();
    tick();
    bus.mem_rdy = 1'b0;
    tick();
    check("illegal T3 enable",    bus.enable, 32'h0);
    check("illegal T3 busSelect", bus.busSelect, 32'h0);
    check("illegal T3 fault",     32'(bus.fault), 32'h1);
    tick();
    check("illegal fault",  32'(bus.fault), 32'h1);
    check("illegal busy",   32'(bus.busy), 32'h0);
    check("illegal enable", bus.enable, 32'h0);
    pulse_clr();

    // Memory timeout: 15 T1 cycles with no mem_rdy
    bus.ir = 32'h2891_8000;
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    bus.mem_rdy = 1'b0;
    tick();
    for (int k = 1; k < 15; k++) begin
      tick();
      check("timeout wait busy",  32'(bus.busy), 32'h1);
      check("timeout wait fault", 32'(bus.fault), 32'h0);
    end
    check("timeout 15th MD_Read", 32'(bus.MD_Read), 32'h1);
    tick();
    check("timeout fault", 32'(bus.fault), 32'h1);
    check_quiet("timeout");
    bus.run = 1'b1;
    bus.mem_rdy = 1'b1;
    repeat (3) tick();
    check("fault sticky", 32'(bus.fault), 32'h1);
    check("fault sticky busy", 32'(bus.busy), 32'h0);
    bus.run = 1'b0;
    bus.mem_rdy = 1'b0;
    pulse_clr();
    check_quiet("final idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
